accum_bank: RTL
===============

ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 16, accumulator and data width in bits (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4, number of independent accumulators (>=2, power of two).
REQ-003 SHALL derive localparam CH_W = clog2(CHANNELS), channel index width.
REQ-004 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port IN_VALID  input  1  operation request.
REQ-007 SHALL have port IN_READY  output  1  block accepts a request this cycle.
REQ-008 SHALL have port IN_CH  input  CH_W  target channel.
REQ-009 SHALL have port IN_OP  input  2  opcode: 00 ADD, 01 SUB, 10 LOAD, 11 CLEAR.
REQ-010 SHALL have port D  input  WIDTH  operand, unsigned.
REQ-011 SHALL have port CLR_ALL  input  1  request to zero every channel.
REQ-012 SHALL have port OUT_VALID  output  1  result strobe, one cycle.
REQ-013 SHALL have port OUT_CH  output  CH_W  channel of current result.
REQ-014 SHALL have port Q  output  WIDTH  new value of OUT_CH after the operation.
REQ-015 SHALL have port OVF  output  1  carry (ADD) or borrow (SUB) of current result; 0 for LOAD/CLEAR.

Function
REQ-016 SHALL accept a request on a rising edge where IN_VALID=1 and IN_READY=1; otherwise it SHALL change no accumulator.
REQ-017 SHALL compute ADD acc+D, SUB acc-D, LOAD D, CLEAR 0, all modulo 2^WIDTH, and write the result to accumulator IN_CH.
REQ-018 SHALL present OUT_VALID=1, OUT_CH, Q and OVF exactly one cycle after acceptance, and OUT_VALID=0 in every other cycle.
REQ-019 SHALL apply back-to-back requests to the same channel in consecutive cycles with the second using the first's result (no hazard, throughput one per cycle).
REQ-020 SHALL implement states IDLE and SWEEP; IDLE holds IN_READY=1, SWEEP holds IN_READY=0.
REQ-021 SHALL, on CLR_ALL=1 in IDLE, go to SWEEP and zero one channel per cycle from 0 up to CHANNELS-1, then return to IDLE; sweep takes CHANNELS cycles.
REQ-022 SHALL, when CLR_ALL=1 and IN_VALID=1 in the same IDLE cycle, give CLR_ALL priority and not accept the request.
REQ-023 SHALL ignore CLR_ALL while in SWEEP and emit no OUT_VALID for sweep writes.

Reset
REQ-024 SHALL, while RST_N=0, force all accumulators to 0, state to IDLE, OUT_VALID=0, OUT_CH=0, Q=0, OVF=0, independent of CLK.
REQ-025 SHALL abort any operation or sweep in progress on reset and accept requests in the first cycle after RST_N deasserts.

Configuration
REQ-026 SHALL, with macro ACCUM_BANK_SAT_EN defined, saturate ADD to 2^WIDTH-1 and SUB to 0 on carry/borrow, OVF still reporting the event.
REQ-027 SHALL, without ACCUM_BANK_SAT_EN, wrap modulo 2^WIDTH as in REQ-017.

Structure
REQ-028 SHALL place opcode constants (OP_ADD, OP_SUB, OP_LOAD, OP_CLEAR) and state encoding in shared package accum_bank_pkg.
REQ-029 SHALL contain one sub-module accum_alu: combinational acc/D/op to result and OVF, including saturation logic.

Verification (WIDTH=16, CHANNELS=4, wrap unless stated)
REQ-030 SHALL check: reset, LOAD ch1 D=0x1234, ADD ch1 D=0x0001 back-to-back -> Q=0x1234 then Q=0x1235, OVF=0, OUT_CH=1 both.
REQ-031 SHALL check: LOAD ch2 0xFFFF, ADD ch2 0x0002 -> Q=0x0001, OVF=1; with ACCUM_BANK_SAT_EN -> Q=0xFFFF, OVF=1.
REQ-032 SHALL check: ch3 = 0, SUB ch3 0x0001 -> Q=0xFFFF, OVF=1; with ACCUM_BANK_SAT_EN -> Q=0x0000, OVF=1.
REQ-033 SHALL check: all channels loaded 0x00AA, CLR_ALL with IN_VALID ADD ch0 same cycle -> IN_READY=0 four cycles, no OUT_VALID, then ADD ch0..ch3 D=1 each give Q=0x0001.
REQ-034 SHALL check: RST_N pulsed low mid-sweep with ch0 = 0x5555 -> outputs 0 at once, IN_READY=1 next cycle, ADD ch0 D=0 gives Q=0x0000.
REQ-035 SHALL check: interleaved ADD ch0 0x0010, ADD ch1 0x0020, ADD ch0 0x0001 -> ch0 Q=0x0010, ch1 Q=0x0020, ch0 Q=0x0011.

Source files
------------

// File: rtl/accum_bank_pkg.sv
// Shared opcodes and FSM state encoding for the accumulator bank.
// Imported by accum_alu and accum_bank.
package accum_bank_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

endpackage

// File: rtl/accum_alu.sv
// Combinational accumulator update: acc/D/op to result and carry/borrow.
// Macro ACCUM_BANK_SAT_EN clamps ADD/SUB instead of wrapping.
module accum_alu
  import accum_bank_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] d,
  input  op_t              op,
  output logic [WIDTH-1:0] res,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // select result; carry/borrow comes from the extra top bit
  always_comb begin
    sum  = {1'b0, acc} + {1'b0, d};
    diff = {1'b0, acc} - {1'b0, d};
    res  = '0;
    ovf  = 1'b0;
    unique case (op)
      OP_ADD: begin
        ovf = sum[WIDTH];
        res = sum[WIDTH-1:0];
`ifdef ACCUM_BANK_SAT_EN
        if (ovf) res = '1;
`endif
      end
      OP_SUB: begin
        ovf = diff[WIDTH];
        res = diff[WIDTH-1:0];
`ifdef ACCUM_BANK_SAT_EN
        if (ovf) res = '0;
`endif
      end
      OP_LOAD:  res = d;
      OP_CLEAR: res = '0;
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/accum_bank.sv
// Bank of CHANNELS accumulators with one-per-cycle ops and a clear sweep.
// Optional macro ACCUM_BANK_SAT_EN selects saturating ADD/SUB.
module accum_bank
  import accum_bank_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [CH_W-1:0] IN_CH,
  input  logic [1:0]      IN_OP,
  input  logic [WIDTH-1:0] D,
  input  logic            CLR_ALL,
  output logic            OUT_VALID,
  output logic [CH_W-1:0] OUT_CH,
  output logic [WIDTH-1:0] Q,
  output logic            OVF
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

  logic [WIDTH-1:0] acc [CHANNELS];
  state_t           state;
  state_t           state_nxt;
  logic [CH_W-1:0]  sweep_cnt;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign IN_READY = (state == IDLE);
  assign accept   = IN_VALID && IN_READY && !CLR_ALL;

  accum_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .acc (acc[IN_CH]),
    .d   (D),
    .op  (op_t'(IN_OP)),
    .res (alu_res),
    .ovf (alu_ovf)
  );

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: CLR_ALL starts a sweep, last channel ends it
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (CLR_ALL) state_nxt = SWEEP;
      SWEEP:   if (sweep_cnt == LAST_CH) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // accumulator writes: sweep zeroes one channel per cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
      sweep_cnt <= '0;
    end else if (state == SWEEP) begin
      acc[sweep_cnt] <= '0;
      sweep_cnt      <= sweep_cnt + 1'b1;
    end else begin
      sweep_cnt <= '0;
      if (accept) acc[IN_CH] <= alu_res;
    end
  end

  // result register: strobe for one cycle, hold data
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OUT_VALID <= 1'b0;
      OUT_CH    <= '0;
      Q         <= '0;
      OVF       <= 1'b0;
    end else begin
      OUT_VALID <= accept;
      if (accept) begin
        OUT_CH <= IN_CH;
        Q      <= alu_res;
        OVF    <= alu_ovf;
      end
    end
  end

endmodule
